// File: rtl/mole_controller.sv
// Whack-a-mole game-play controller: round countdown on the divider tick,
// LFSR-chosen mole placement across four holes, and hit scoring.
module mole_controller #(
  parameter int unsigned GAME_TICKS = 30,
  parameter int unsigned MOLE_TICKS = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Start,
  input  logic [3:0] Hit,
  output logic [3:0] Mole,
  output logic [7:0] Score,
  output logic [5:0] TimeLeft,
  output logic       Playing,
  output logic       GameOver
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  localparam logic [5:0] LP_GAME = 6'(GAME_TICKS);
  localparam logic [3:0] LP_MOLE = 4'(MOLE_TICKS);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr;
  logic [3:0] r_mole, w_mole_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic [5:0] r_time, w_time_nxt;
  logic       r_playing, w_playing_nxt;
  logic       r_gameover, w_gameover_nxt;
  logic [3:0] r_mole_cnt, w_mole_cnt_nxt;
  logic [1:0] r_last;
  logic       r_last_vld;

  logic       w_fb;
  logic [1:0] w_idx;
  logic [1:0] w_spawn_idx;
  logic [3:0] w_spawn_oh;
  logic       w_spawn;
  logic       w_hit_ok;

  assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_idx       = r_lfsr[1:0];
  // History survives round boundaries so a new round never reopens the last hole.
  assign w_spawn_idx = (r_last_vld && (w_idx == r_last)) ? w_idx + 2'd1 : w_idx;
  assign w_spawn_oh  = 4'b0001 << w_spawn_idx;
  assign w_hit_ok    = |(Hit & r_mole);

  always_comb begin
    w_state_nxt    = r_state;
    w_mole_nxt     = r_mole;
    w_score_nxt    = r_score;
    w_time_nxt     = r_time;
    w_playing_nxt  = r_playing;
    w_gameover_nxt = r_gameover;
    w_mole_cnt_nxt = r_mole_cnt;
    w_spawn        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (Start) begin
          w_score_nxt    = '0;
          w_time_nxt     = LP_GAME;
          w_mole_nxt     = w_spawn_oh;
          w_mole_cnt_nxt = LP_MOLE;
          w_playing_nxt  = 1'b1;
          w_gameover_nxt = 1'b0;
          w_spawn        = 1'b1;
          w_state_nxt    = SHOW;
        end
      end
      SHOW: begin
        if (Enable && (r_time == 6'd1)) begin
          w_time_nxt     = '0;
          w_mole_nxt     = '0;
          w_playing_nxt  = 1'b0;
          w_gameover_nxt = 1'b1;
          w_state_nxt    = DONE;
          if (w_hit_ok) w_score_nxt = r_score + 8'd1;
        end else if (w_hit_ok) begin
          w_score_nxt = r_score + 8'd1;
          w_mole_nxt  = '0;
          w_state_nxt = GAP;
          if (Enable) w_time_nxt = r_time - 6'd1;
        end else if (Enable) begin
          w_time_nxt = r_time - 6'd1;
          if (r_mole_cnt == 4'd1) begin
            w_mole_nxt     = w_spawn_oh;
            w_mole_cnt_nxt = LP_MOLE;
            w_spawn        = 1'b1;
          end else begin
            w_mole_cnt_nxt = r_mole_cnt - 4'd1;
          end
        end
      end
      GAP: begin
        if (Enable) begin
          if (r_time == 6'd1) begin
            w_time_nxt     = '0;
            w_mole_nxt     = '0;
            w_playing_nxt  = 1'b0;
            w_gameover_nxt = 1'b1;
            w_state_nxt    = DONE;
          end else begin
            w_time_nxt     = r_time - 6'd1;
            w_mole_nxt     = w_spawn_oh;
            w_mole_cnt_nxt = LP_MOLE;
            w_spawn        = 1'b1;
            w_state_nxt    = SHOW;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_lfsr     <= LFSR_SEED;
      r_mole     <= '0;
      r_score    <= '0;
      r_time     <= '0;
      r_playing  <= 1'b0;
      r_gameover <= 1'b0;
      r_mole_cnt <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= {r_lfsr[6:0], w_fb};
      r_mole     <= w_mole_nxt;
      r_score    <= w_score_nxt;
      r_time     <= w_time_nxt;
      r_playing  <= w_playing_nxt;
      r_gameover <= w_gameover_nxt;
      r_mole_cnt <= w_mole_cnt_nxt;
      if (w_spawn) begin
        r_last     <= w_spawn_idx;
        r_last_vld <= 1'b1;
      end
    end
  end

  assign Mole     = r_mole;
  assign Score    = r_score;
  assign TimeLeft = r_time;
  assign Playing  = r_playing;
  assign GameOver = r_gameover;

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller: round start, scoring, mole rotation,
// round end, idle/done insensitivity and mid-round reset.
module tb_mole_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Hit = '0;
  logic [3:0] Mole;
  logic [7:0] Score;
  logic [5:0] TimeLeft;
  logic       Playing;
  logic       GameOver;

  mole_controller #(
    .GAME_TICKS(30),
    .MOLE_TICKS(2),
    .LFSR_SEED (8'hA5)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .Start   (Start),
    .Hit     (Hit),
    .Mole    (Mole),
    .Score   (Score),
    .TimeLeft(TimeLeft),
    .Playing (Playing),
    .GameOver(GameOver)
  );

  always #5 Clk = ~Clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference LFSR and spawn history
  logic [7:0] m_lfsr;
  logic [1:0] m_last = '0;
  logic       m_vld  = 1'b0;
  logic [3:0] m_mole = '0;
  int         m_time = 0;
  int         m_cnt  = 0;
  bit         m_gap  = 1'b0;
  int         m_score = 0;

  always @(posedge Clk)
    m_lfsr <= Reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic spawn_exp(output logic [3:0] oh);
    logic [1:0] idx;
    idx = m_lfsr[1:0];
    if (m_vld && idx == m_last) idx = idx + 2'd1;
    m_last = idx;
    m_vld  = 1'b1;
    oh = 4'b0001 << idx;
  endtask

  task automatic step(input logic en, input logic st, input logic [3:0] h);
    Enable = en;
    Start  = st;
    Hit    = h;
    @(posedge Clk);
    #1;
    Enable = 1'b0;
    Start  = 1'b0;
    Hit    = '0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] mo, input int sc,
                         input int tl, input logic pl, input logic go);
    chk({tag, ".mole"}, Mole, mo);
    chk({tag, ".score"}, Score, sc);
    chk({tag, ".time"}, TimeLeft, tl);
    chk({tag, ".play"}, Playing, pl);
    chk({tag, ".over"}, GameOver, go);
  endtask

  // One no-hit tick in SHOW/GAP with TimeLeft > 1
  task automatic tick_nohit();
    logic [3:0] e_mole;
    logic [3:0] prev;
    bit         resp;
    prev = Mole;
    resp = m_gap || (m_cnt == 1);
    if (resp) begin
      spawn_exp(e_mole);
      m_cnt = 2;
      m_gap = 1'b0;
    end else begin
      e_mole = m_mole;
      m_cnt--;
    end
    step(1'b1, 1'b0, '0);
    m_time--;
    m_mole = e_mole;
    chk("tick.time", TimeLeft, m_time);
    chk("tick.mole", Mole, e_mole);
    chk("tick.onehot", $countones(Mole), 1);
    if (resp && prev != 4'b0000) chk("tick.newhole", (Mole != prev), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk_all("reset", 4'b0, 0, 0, 1'b0, 1'b0);
    Reset = 1'b0;

    // Idle with Enable pulses and stray hits: nothing moves
    for (int i = 0; i < 10; i++) begin
      step(i[0], 1'b0, 4'hF);
      chk_all("idle", 4'b0, 0, 0, 1'b0, 1'b0);
    end

    // Round 1: start
    spawn_exp(m_mole);
    step(1'b0, 1'b1, '0);
    m_time = 30; m_cnt = 2; m_gap = 1'b0; m_score = 0;
    chk_all("start1", m_mole, 0, 30, 1'b1, 1'b0);
    chk("start1.onehot", $countones(Mole), 1);

    // Correct hit -> GAP
    step(1'b0, 1'b0, m_mole);
    m_score = 1; m_gap = 1'b1;
    chk("hit1.score", Score, 1);
    chk("hit1.mole", Mole, 0);

    // Hits ignored in GAP
    step(1'b0, 1'b0, 4'hF);
    chk("gaphit.score", Score, 1);
    chk("gaphit.mole", Mole, 0);

    // Enable in GAP respawns
    tick_nohit();
    chk("gapen.time29", TimeLeft, 29);

    // Wrong-only hit: no change
    step(1'b0, 1'b0, ~m_mole);
    chk("wrong.score", Score, 1);
    chk("wrong.mole", Mole, m_mole);

    // Start while playing ignored
    step(1'b0, 1'b1, '0);
    chk("restart.time", TimeLeft, 29);
    chk("restart.score", Score, 1);

    // All-holes hit counts as correct
    step(1'b0, 1'b0, 4'hF);
    m_score = 2; m_gap = 1'b1;
    chk("allhit.score", Score, 2);
    chk("allhit.mole", Mole, 0);

    // Run out the round with idle gaps between ticks
    while (m_time > 1) begin
      tick_nohit();
      step(1'b0, 1'b0, '0);
      chk("hold.time", TimeLeft, m_time);
    end

    // Last tick with coincident correct hit: scores and ends
    step(1'b1, 1'b0, m_mole);
    chk_all("lasthit", 4'b0, 3, 0, 1'b0, 1'b1);

    // DONE ignores Enable and Hit
    step(1'b1, 1'b0, 4'hF);
    chk_all("done", 4'b0, 3, 0, 1'b0, 1'b1);

    // Round 2: start with coincident Enable (ignored)
    spawn_exp(m_mole);
    step(1'b1, 1'b1, '0);
    m_time = 30; m_cnt = 2; m_gap = 1'b0;
    chk_all("start2", m_mole, 0, 30, 1'b1, 1'b0);

    // Hit together with Enable: score, clear, decrement
    step(1'b1, 1'b0, m_mole);
    m_time = 29; m_gap = 1'b1;
    chk_all("hiten", 4'b0, 1, 29, 1'b1, 1'b0);

    while (m_time > 1) tick_nohit();
    step(1'b1, 1'b0, '0);
    chk_all("end2", 4'b0, 1, 0, 1'b0, 1'b1);

    // Round 3: reset mid-round has priority
    spawn_exp(m_mole);
    step(1'b0, 1'b1, '0);
    m_time = 30; m_cnt = 2; m_gap = 1'b0;
    chk_all("start3", m_mole, 0, 30, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick_nohit();
    Reset = 1'b1;
    step(1'b1, 1'b1, 4'hF);
    chk_all("midreset", 4'b0, 0, 0, 1'b0, 1'b0);
    Reset = 1'b0;
    m_vld = 1'b0;
    m_last = '0;
    step(1'b1, 1'b0, '0);
    chk_all("postreset", 4'b0, 0, 0, 1'b0, 1'b0);

    // Fresh start after reset uses seeded history again
    spawn_exp(m_mole);
    step(1'b0, 1'b1, '0);
    chk_all("start4", m_mole, 0, 30, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Game-play controller for the whack-a-mole board, directly downstream of the 1 Hz rate divider. It consumes the divider's one-cycle `Enable` tick as the game time base and runs the round countdown. It chooses which of four holes shows a mole using a free-running LFSR, scores debounced key hits, and drives the LED/display and screen logic.

## Interface
Parameters:
- `GAME_TICKS`, default 30: round length in `Enable` ticks, range 1..63.
- `MOLE_TICKS`, default 2: number of ticks an unhit mole stays lit, range 1..15.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Enable`  in  1  one-cycle tick from the rate divider.
- `Start`  in  1  level/pulse; begins a round when idle or game over.
- `Hit`  in  4  one-cycle debounced key pulses, bit i = hole i.
- `Mole`  out  4  one-hot lit hole, or 0.
- `Score`  out  8  hits this round.
- `TimeLeft`  out  6  remaining ticks.
- `Playing`  out  1  high while a round runs.
- `GameOver`  out  1  high after round end until next Start/Reset.

## Operation
- All outputs and state are registered. Reset gives `Mole`=0, `Score`=0, `TimeLeft`=0, `Playing`=0, `GameOver`=0, state IDLE, lfsr=`LFSR_SEED`, mole_cnt=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle in every state except during reset. Spawn index = lfsr[1:0] in the spawning cycle. If the index equals the currently/last lit hole, use (index+1) mod 4 instead, so consecutive moles never share a hole.
- States: IDLE, SHOW, GAP, DONE.
- IDLE/DONE, `Start`=1: `Score`←0, `TimeLeft`←`GAME_TICKS`, `Mole`←spawn, mole_cnt←`MOLE_TICKS`, `Playing`←1, `GameOver`←0, go to SHOW. A coincident `Enable` is ignored. `Enable` and `Hit` are otherwise ignored in IDLE/DONE.
- SHOW, evaluated per cycle with this priority:
  1. `Enable`=1 and `TimeLeft`=1: `TimeLeft`←0, `Mole`←0, `Playing`←0, `GameOver`←1, go to DONE. A correct hit in the same cycle still increments `Score`.
  2. Correct hit (`Hit & Mole` ≠ 0; extra wrong bits don't matter): `Score`←`Score`+1, `Mole`←0, go to GAP. If `Enable` is also high, `TimeLeft` decrements.
  3. `Enable`=1: `TimeLeft`−1 and mole_cnt−1. If mole_cnt was 1, respawn `Mole` and reload mole_cnt; stay in SHOW.
  4. A wrong-only hit does nothing (no penalty).
- GAP: `Mole`=0. On `Enable`: if `TimeLeft`=1, go to DONE as in rule 1. Otherwise `TimeLeft`−1, spawn, reload mole_cnt, go to SHOW. `Hit` is ignored.
- `Start` while in SHOW or GAP is ignored.
- Score cannot exceed `GAME_TICKS` (at most one hit per tick), so it needs no saturation. 8 bits is sufficient.

## Timing
- Every response appears on the outputs one cycle after the input edge: hit→`Score`/`Mole` clear is 1 cycle; `Start`→`Playing` is 1 cycle; `Enable`→`TimeLeft` is 1 cycle.
- Each accepted `Enable` decrements `TimeLeft` exactly once. No multi-cycle paths.
- `Reset` mid-round returns all outputs to their reset values on the next edge and has priority over every other input.
- `Enable` is assumed to be at most one cycle wide. A held `Enable` counts once per cycle; the design requires no pulse-width check.

## Test plan
- Reset, then idle 10 cycles with `Enable` pulses -> `Mole`=0, `Score`=0, `TimeLeft`=0, `Playing`=0, `GameOver`=0 throughout.
- `Start` (`GAME_TICKS`=30) -> next cycle `Playing`=1, `TimeLeft`=30, `Mole` one-hot. Pulse the correct `Hit` -> next cycle `Score`=1, `Mole`=0. Next `Enable` -> `TimeLeft`=29, `Mole` one-hot.
- In SHOW, pulse a wrong-hole `Hit` -> `Score` and `Mole` unchanged. Pulse `Hit`=4'b1111 -> `Score`+1.
- No hits, `MOLE_TICKS`=2 -> `Mole` changes after every 2nd `Enable`, always one-hot, never the same hole twice in a row.
- 30 `Enable` ticks -> `TimeLeft`=0, `GameOver`=1, `Playing`=0, `Mole`=0. Further `Enable` changes nothing. `Start` -> `Score`=0, `TimeLeft`=30.
- With `TimeLeft`=1, correct `Hit`+`Enable` in the same cycle -> `Score`+1 and DONE. `Reset` asserted mid-round -> all outputs at reset values next cycle.
